// File: rtl/ov7670_yuv_capture_pkg.sv
// Shared types and constants for the OV7670 YUV422 capture block.
package ov7670_yuv_capture_pkg;

  localparam int CNT_W        = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    S_SYNC,
    S_SKIP,
    S_IDLE,
    S_CAPT
  } cap_state_e;

endpackage

// File: rtl/ov7670_yuv_capture_sync_edge.sv
// Registers the sensor sync lines once and emits edge strobes relative to that copy.
module ov_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic href_i,
  input  logic vsync_i,
  output logic vs_rise_o,
  output logic vs_fall_o,
  output logic href_fall_o
);

  logic href_q;
  logic vsync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= href_i;
      vsync_q <= vsync_i;
    end
  end

  assign vs_rise_o   = vsync_i & ~vsync_q;
  assign vs_fall_o   = ~vsync_i & vsync_q;
  assign href_fall_o = ~href_i & href_q;

endmodule

// File: rtl/ov7670_yuv_capture.sv
// Pairs OV7670 YUV422 bytes into {chroma, Y} words with pixel/line indices and frame pulses.
// Define OV_LINE_CHECK_EN to add the sticky oLINE_ERR line-length monitor.
module ov7670_yuv_capture
  import ov7670_yuv_capture_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 2
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [7:0]       iDATA,
  input  logic             iHREF,
  input  logic             iVSYNC,
  input  logic             iEN,
  output logic [15:0]      oYCbCr,
  output logic             oDVAL,
  output logic [CNT_W-1:0] oX,
  output logic [CNT_W-1:0] oY,
  output logic             oFRAME_START,
  output logic             oFRAME_DONE
`ifdef OV_LINE_CHECK_EN
  ,
  output logic             oLINE_ERR
`endif
);

  localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_ACTIVE);
  localparam logic [3:0]       SKIP_LD = 4'(SKIP_FRAMES);

  logic vs_rise;
  logic vs_fall;
  logic href_fall;

  ov_sync_edge u_sync_edge (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .href_i      (iHREF),
    .vsync_i     (iVSYNC),
    .vs_rise_o   (vs_rise),
    .vs_fall_o   (vs_fall),
    .href_fall_o (href_fall)
  );

  cap_state_e       state_q;
  logic [3:0]       skip_q;
  logic             phase_q;
  logic [7:0]       chroma_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] word_cnt_d;
  logic [CNT_W-1:0] line_cnt_q;
  logic             line_has_word_q;
  logic             frame_has_word_q;
  logic [15:0]      ycbcr_q;
  logic             dval_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             start_q;
  logic             done_q;

  logic frame_go;
  logic pair_go;
  logic word_ok;

  assign frame_go   = (state_q == S_IDLE) && vs_fall && iEN;
  // A VSYNC rise aborts the line, so a pair completing on that edge is discarded.
  assign pair_go    = (state_q == S_CAPT) && iHREF && phase_q && !vs_rise;
  assign word_ok    = pair_go && (word_cnt_q < H_LIM) && (line_cnt_q < V_LIM);
  assign word_cnt_d = (word_cnt_q < H_LIM) ? word_cnt_q + 1'b1 : word_cnt_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q          <= S_SYNC;
      skip_q           <= SKIP_LD;
      phase_q          <= 1'b0;
      chroma_q         <= 8'd0;
      word_cnt_q       <= '0;
      line_cnt_q       <= '0;
      line_has_word_q  <= 1'b0;
      frame_has_word_q <= 1'b0;
      ycbcr_q          <= 16'd0;
      dval_q           <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      start_q          <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      dval_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;

      if (href_fall) begin
        phase_q         <= 1'b0;
        word_cnt_q      <= '0;
        x_q             <= '0;
        line_has_word_q <= 1'b0;
        if (state_q == S_CAPT && line_has_word_q) begin
          line_cnt_q <= line_cnt_q + 1'b1;
        end
      end

      case (state_q)
        S_SYNC: begin
          if (vs_rise) begin
            state_q <= (SKIP_FRAMES == 0) ? S_IDLE : S_SKIP;
            skip_q  <= SKIP_LD;
          end
        end
        S_SKIP: begin
          if (vs_rise) begin
            if (skip_q <= 4'd1) begin
              state_q <= S_IDLE;
            end else begin
              skip_q <= skip_q - 4'd1;
            end
          end
        end
        S_IDLE: begin
          if (frame_go) begin
            state_q          <= S_CAPT;
            start_q          <= 1'b1;
            line_cnt_q       <= '0;
            y_q              <= '0;
            frame_has_word_q <= 1'b0;
            line_has_word_q  <= 1'b0;
            phase_q          <= 1'b0;
            word_cnt_q       <= '0;
          end
        end
        S_CAPT: begin
          if (vs_rise) begin
            state_q    <= S_IDLE;
            done_q     <= frame_has_word_q;
            phase_q    <= 1'b0;
            word_cnt_q <= '0;
          end else if (iHREF) begin
            if (!phase_q) begin
              chroma_q <= iDATA;
              phase_q  <= 1'b1;
            end else begin
              phase_q    <= 1'b0;
              word_cnt_q <= word_cnt_d;
              if (word_ok) begin
                ycbcr_q          <= {chroma_q, iDATA};
                dval_q           <= 1'b1;
                x_q              <= word_cnt_q;
                y_q              <= line_cnt_q;
                line_has_word_q  <= 1'b1;
                frame_has_word_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign oYCbCr       = ycbcr_q;
  assign oDVAL        = dval_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFRAME_START = start_q;
  assign oFRAME_DONE  = done_q;

`ifdef OV_LINE_CHECK_EN
  // One extra bit lets the count saturate above H_ACTIVE so over-long lines are flagged.
  localparam logic [CNT_W:0] H_LEN = (CNT_W + 1)'(H_ACTIVE);

  logic [CNT_W:0] len_q;
  logic           line_err_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      len_q      <= '0;
      line_err_q <= 1'b0;
    end else begin
      if (frame_go) begin
        line_err_q <= 1'b0;
      end
      if (href_fall) begin
        len_q <= '0;
        if (state_q == S_CAPT && len_q != H_LEN) begin
          line_err_q <= 1'b1;
        end
      end else if (pair_go && len_q <= H_LEN) begin
        len_q <= len_q + 1'b1;
      end
    end
  end

  assign oLINE_ERR = line_err_q;
`endif

endmodule

// File: tb/tb_ov7670_yuv_capture.sv
// Randomized bench for ov7670_yuv_capture with a frame/line-level reference model.
module tb_ov7670_yuv_capture;

  localparam int H    = 4;
  localparam int V    = 2;
  localparam int SKIP = 2;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [15:0] w;
    int          x;
    int          y;
    int          c;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        href;
  logic        vsync;
  logic        en;
  logic [15:0] oYCbCr;
  logic        oDVAL;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic        oFRAME_START;
  logic        oFRAME_DONE;
`ifdef OV_LINE_CHECK_EN
  logic        line_err;
`endif

  ov7670_yuv_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SKIP)
  ) dut (
    .iCLK         (clk),
    .iRST         (rst),
    .iDATA        (data),
    .iHREF        (href),
    .iVSYNC       (vsync),
    .iEN          (en),
    .oYCbCr       (oYCbCr),
    .oDVAL        (oDVAL),
    .oX           (oX),
    .oY           (oY),
    .oFRAME_START (oFRAME_START),
    .oFRAME_DONE  (oFRAME_DONE)
`ifdef OV_LINE_CHECK_EN
    ,
    .oLINE_ERR    (line_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int obs_words = 0;
  bit mon_en = 1'b0;

  // Reference model state: expectations derived from frame/line rules.
  word_t       exp_q[$];
  int          exp_start[$];
  int          exp_done[$];
  int          rises;
  bit          in_capt;
  int          line_idx;
  int          frame_words;
  logic [15:0] last_word;
  bit          err_exp;

  task automatic model_reset();
    rises = 0; in_capt = 0; line_idx = 0; frame_words = 0;
    last_word = 16'd0; err_exp = 0;
  endtask

  function automatic bytes_t rand_bytes(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  word_t mon_e;
  int    mon_c;
  always @(negedge clk) begin
    if (mon_en) begin
      if (oDVAL === 1'b1) begin
        obs_words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_extra: got %h x=%0d y=%0d cyc=%0d, required no word", oYCbCr, oX, oY, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (oYCbCr !== mon_e.w || oX !== 10'(mon_e.x) || oY !== 10'(mon_e.y) || cyc != mon_e.c) begin
            errors++;
            $display("FAIL word: got %h x=%0d y=%0d cyc=%0d, required %h x=%0d y=%0d cyc=%0d",
                     oYCbCr, oX, oY, cyc, mon_e.w, mon_e.x, mon_e.y, mon_e.c);
          end
        end
      end
      if (oFRAME_START === 1'b1) begin
        checks++;
        mon_c = (exp_start.size() != 0) ? exp_start.pop_front() : -1;
        if (mon_c != cyc) begin
          errors++;
          $display("FAIL frame_start: got pulse at cyc=%0d, required cyc=%0d", cyc, mon_c);
        end
      end
      if (oFRAME_DONE === 1'b1) begin
        checks++;
        mon_c = (exp_done.size() != 0) ? exp_done.pop_front() : -1;
        if (mon_c != cyc) begin
          errors++;
          $display("FAIL frame_done: got pulse at cyc=%0d, required cyc=%0d", cyc, mon_c);
        end
      end
    end
  end

  // VSYNC pulse; abort keeps HREF high (with a byte) on the rising cycle.
  task automatic vs_pulse(input bit en_v, input bit abort);
    @(negedge clk);
    vsync = 1'b1;
    rises++;
    href = abort;
    data = 8'($urandom);
    if (in_capt) begin
      in_capt = 0;
      if (frame_words > 0) exp_done.push_back(cyc + 1);
    end
    @(negedge clk);
    href = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    en = en_v;
    if (rises >= SKIP + 1 && en_v) begin
      in_capt = 1; line_idx = 0; frame_words = 0; err_exp = 0;
      exp_start.push_back(cyc + 1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_line(input bytes_t b, input bit keep_high);
    bit    got;
    word_t e;
    got = 0;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      href = 1'b1;
      data = b[i];
      if (in_capt && (i % 2) == 1 && (i / 2) < H && line_idx < V) begin
        e.w = {b[i-1], b[i]}; e.x = i / 2; e.y = line_idx; e.c = cyc + 1;
        exp_q.push_back(e);
        last_word = e.w;
        got = 1;
        frame_words++;
      end
    end
    if (!keep_high) begin
      @(negedge clk);
      href = 1'b0;
      data = 8'($urandom);
      if (in_capt) begin
        if (got) line_idx++;
        if (b.size() / 2 != H) err_exp = 1;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (oDVAL !== 1'b0) begin errors++; $display("FAIL reset_dval: got %b, required 0", oDVAL); end
    checks++; if (oYCbCr !== 16'd0) begin errors++; $display("FAIL reset_data: got %h, required 0000", oYCbCr); end
    checks++; if (oX !== 10'd0 || oY !== 10'd0) begin errors++; $display("FAIL reset_xy: got x=%0d y=%0d, required 0 0", oX, oY); end
    checks++; if (oFRAME_START !== 1'b0 || oFRAME_DONE !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got start=%b done=%b, required 0 0", oFRAME_START, oFRAME_DONE);
    end
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_skip_frames();
    int w0;
    w0 = obs_words;
    for (int f = 0; f < 3; f++) begin
      vs_pulse(1'b1, 1'b0);
      for (int l = 0; l < 2; l++) send_line(rand_bytes(8), 1'b0);
    end
    vs_pulse(1'b1, 1'b0);
    checks++; if (obs_words - w0 != 8) begin errors++; $display("FAIL skip_word_count: got %0d, required 8", obs_words - w0); end
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL skip_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
  endtask

  task automatic test_pixel_pairing();
    bytes_t pq;
    pq.push_back(8'h80); pq.push_back(8'h10); pq.push_back(8'h90); pq.push_back(8'h20);
    send_line(pq, 1'b0);
    checks++; if (oYCbCr !== 16'h9020) begin errors++; $display("FAIL pair_hold: got %h, required 9020", oYCbCr); end
    send_line(rand_bytes(8), 1'b0);
    vs_pulse(1'b1, 1'b0);
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL pair_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
  endtask

  task automatic test_line_length();
    send_line(rand_bytes(10), 1'b0);
    send_line(rand_bytes(7), 1'b0);
    send_line(rand_bytes(8), 1'b0);
`ifdef OV_LINE_CHECK_EN
    checks++; if (line_err !== err_exp) begin errors++; $display("FAIL line_err: got %b, required %b", line_err, err_exp); end
`endif
    checks++; if (oYCbCr !== last_word) begin errors++; $display("FAIL len_hold: got %h, required %h", oYCbCr, last_word); end
    vs_pulse(1'b1, 1'b0);
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL len_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
  endtask

  task automatic test_abort();
    send_line(rand_bytes(8), 1'b0);
    send_line(rand_bytes(3), 1'b1);
    vs_pulse(1'b1, 1'b1);
    send_line(rand_bytes(8), 1'b0);
    vs_pulse(1'b0, 1'b0);
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL abort_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
    checks++; if (oYCbCr !== last_word) begin errors++; $display("FAIL abort_hold: got %h, required %h", oYCbCr, last_word); end
  endtask

  task automatic test_enable();
    int w0;
    w0 = obs_words;
    send_line(rand_bytes(8), 1'b0);
    checks++; if (obs_words != w0) begin errors++; $display("FAIL en_off_words: got %0d, required 0", obs_words - w0); end
    vs_pulse(1'b1, 1'b0);
    send_line(rand_bytes(8), 1'b0);
    vs_pulse(1'b1, 1'b0);
    checks++; if (obs_words - w0 != 4) begin errors++; $display("FAIL en_on_words: got %0d, required 4", obs_words - w0); end
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL en_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
  endtask

  task automatic test_reset_mid();
    send_line(rand_bytes(3), 1'b1);
    @(negedge clk);
    rst = 1'b1; href = 1'b1; data = 8'($urandom);
    @(negedge clk);
    checks++; if (oDVAL !== 1'b0) begin errors++; $display("FAIL rstmid_dval: got %b, required 0", oDVAL); end
    checks++; if (oYCbCr !== 16'd0 || oX !== 10'd0 || oY !== 10'd0) begin
      errors++; $display("FAIL rstmid_out: got %h x=%0d y=%0d, required 0000 0 0", oYCbCr, oX, oY);
    end
    rst = 1'b0; href = 1'b0;
    model_reset();
    for (int f = 0; f < 3; f++) begin
      vs_pulse(1'b1, 1'b0);
      send_line(rand_bytes(8), 1'b0);
    end
    vs_pulse(1'b0, 1'b0);
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL rstmid_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
    checks++; if (oYCbCr !== last_word) begin errors++; $display("FAIL rstmid_hold: got %h, required %h", oYCbCr, last_word); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 5; f++) begin
      vs_pulse(($urandom_range(0, 3) != 0), 1'b0);
      for (int l = 0; l < int'($urandom_range(1, 3)); l++) begin
        send_line(rand_bytes($urandom_range(2, 10)), 1'b0);
      end
`ifdef OV_LINE_CHECK_EN
      checks++; if (line_err !== err_exp) begin errors++; $display("FAIL b2b_line_err: got %b, required %b", line_err, err_exp); end
`endif
    end
    vs_pulse(1'b0, 1'b0);
    checks++; if (exp_q.size() + exp_start.size() + exp_done.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d outstanding, required 0", exp_q.size() + exp_start.size() + exp_done.size());
    end
    checks++; if (oYCbCr !== last_word) begin errors++; $display("FAIL b2b_hold: got %h, required %h", oYCbCr, last_word); end
  endtask

  initial begin
    rst = 1'b1; data = 8'd0; href = 1'b0; vsync = 1'b0; en = 1'b1;
    model_reset();
    test_reset();
    test_skip_frames();
    test_pixel_pairing();
    test_line_length();
    test_abort();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
